// File: rtl/onehot_scan_decoder_if.sv
// Command/result handshake bundle for the one-hot scan decoder.
// master drives commands and consumes results; slave is the decoder.
interface onehot_scan_decoder_if #(
    parameter int SEL_W   = 5,
    parameter int DWELL_W = 8
);
    localparam int OUT_W = 2 ** SEL_W;

    logic               in_valid;
    logic               in_ready;
    logic [SEL_W-1:0]   sel;
    logic [1:0]         mode;
    logic [DWELL_W-1:0] dwell;
    logic [OUT_W-1:0]   out;
    logic               out_valid;
    logic               out_ready;
    logic               busy;
    logic               done;

    modport master (
        output in_valid, sel, mode, dwell, out_ready,
        input  in_ready, out, out_valid, busy, done
    );

    modport slave (
        input  in_valid, sel, mode, dwell, out_ready,
        output in_ready, out, out_valid, busy, done
    );
endinterface

// File: rtl/onehot_scan_decoder.sv
// Registered one-hot / thermometer / inverted decoder with a
// dwell-paced scan mode that walks one-hot(0..sel).
module onehot_scan_decoder #(
    parameter int SEL_W   = 5,
    parameter int DWELL_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    onehot_scan_decoder_if.slave bus
);
    localparam int OUT_W = 2 ** SEL_W;
    localparam logic [OUT_W-1:0] ONE = OUT_W'(1);
    localparam logic [OUT_W-1:0] ALL = '1;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        SCAN
    } state_t;

    state_t             state, state_n;
    logic [OUT_W-1:0]   out_q, out_n;
    logic [SEL_W-1:0]   idx_q, idx_n;
    logic [SEL_W-1:0]   sel_q, sel_n;
    logic [DWELL_W-1:0] cnt_q, cnt_n;
    logic [DWELL_W-1:0] dwell_q, dwell_n;
    logic               done_q, done_n;
    logic [OUT_W-1:0]   hot_sel;
    logic [OUT_W-1:0]   therm;

    assign hot_sel = ONE << bus.sel;
    // double shift keeps sel = OUT_W-1 from needing a wider shift
    assign therm   = ~((ALL << bus.sel) << 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            out_q   <= '0;
            idx_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            dwell_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            out_q   <= out_n;
            idx_q   <= idx_n;
            sel_q   <= sel_n;
            cnt_q   <= cnt_n;
            dwell_q <= dwell_n;
            done_q  <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        out_n   = out_q;
        idx_n   = idx_q;
        sel_n   = sel_q;
        cnt_n   = cnt_q;
        dwell_n = dwell_q;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    sel_n   = bus.sel;
                    dwell_n = bus.dwell;
                    idx_n   = '0;
                    cnt_n   = bus.dwell;
                    unique case (1'b1)
                        (bus.mode == 2'b00): begin
                            state_n = HOLD;
                            out_n   = hot_sel;
                        end
                        (bus.mode == 2'b01): begin
                            state_n = HOLD;
                            out_n   = therm;
                        end
                        (bus.mode == 2'b11): begin
                            state_n = HOLD;
                            out_n   = ~hot_sel;
                        end
                        default: begin
                            state_n = SCAN;
                            out_n   = ONE;
                        end
                    endcase
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_n = IDLE;
                    out_n   = '0;
                    cnt_n   = '0;
                    done_n  = 1'b1;
                end
            end
            SCAN: begin
                if (cnt_q != '0) begin
                    cnt_n = cnt_q - 1'b1;
                end else if (bus.out_ready) begin
                    if (idx_q == sel_q) begin
                        state_n = IDLE;
                        out_n   = '0;
                        idx_n   = '0;
                        done_n  = 1'b1;
                    end else begin
                        idx_n = idx_q + 1'b1;
                        cnt_n = dwell_q;
                        out_n = ONE << (idx_q + 1'b1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
                out_n   = '0;
            end
        endcase
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.out       = out_q;
    assign bus.done      = done_q;
    assign bus.out_valid = (state == HOLD) ||
                           ((state == SCAN) && (cnt_q == '0));
endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Randomized bench for onehot_scan_decoder against a transfer-list
// model: each command maps to an expected list of words and gaps.
module tb_onehot_scan_decoder;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    onehot_scan_decoder_if #(.SEL_W(5), .DWELL_W(8)) bus ();
    onehot_scan_decoder_if #(.SEL_W(3), .DWELL_W(8)) bus3 ();

    onehot_scan_decoder #(.SEL_W(5), .DWELL_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    onehot_scan_decoder #(.SEL_W(3), .DWELL_W(8)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    int passed = 0;
    int total  = 0;

    logic [31:0] got_w[$];
    int          got_gap[$];
    bit          got_done;
    bit          timed_out;
    int          stall_bad;
    int          overlap;
    logic [31:0] done_out;
    logic        done_vld;

    function automatic logic [31:0] ref_word(int m, int s);
        longint one = 1;
        case (m)
            1:       return 32'((one << (s + 1)) - 1);
            3:       return ~32'(one << s);
            default: return 32'(one << s);
        endcase
    endfunction

    task automatic send(int s, int m, int d);
        bus.sel      = s[4:0];
        bus.mode     = m[1:0];
        bus.dwell    = d[7:0];
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic collect(int pct);
        int          gap = 0;
        bit          prev_stall = 0;
        logic [31:0] prev_out = '0;
        got_w.delete();
        got_gap.delete();
        got_done  = 0;
        timed_out = 1;
        stall_bad = 0;
        overlap   = 0;
        done_out  = '1;
        done_vld  = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if (bus.done && bus.out_valid) overlap++;
            if (prev_stall &&
                (bus.out !== prev_out || bus.out_valid !== 1'b1))
                stall_bad++;
            if (bus.done) begin
                got_done  = 1;
                timed_out = 0;
                done_out  = bus.out;
                done_vld  = bus.out_valid;
                bus.out_ready = 1'b0;
                break;
            end
            bus.out_ready = ($urandom_range(99) < pct);
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_out   = bus.out;
            if (bus.out_valid && bus.out_ready) begin
                got_w.push_back(bus.out);
                got_gap.push_back(gap);
                gap = 0;
            end else if (!bus.out_valid) begin
                gap++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bus.in_valid   = 0;
        bus.sel        = '0;
        bus.mode       = '0;
        bus.dwell      = '0;
        bus.out_ready  = 0;
        bus3.in_valid  = 0;
        bus3.sel       = '0;
        bus3.mode      = '0;
        bus3.dwell     = '0;
        bus3.out_ready = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (bus.out !== 32'h0)
            $display("FAIL reset_out got=%h exp=0", bus.out);
        else passed++;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b1)
            $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
        else passed++;
        total++;
        if (bus.out_valid !== 1'b0)
            $display("FAIL reset_out_valid got=%b exp=0",
                     bus.out_valid);
        else passed++;
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0)
            $display("FAIL reset_busy_done got=%b%b exp=00",
                     bus.busy, bus.done);
        else passed++;
        total++;
        if (bus3.in_ready !== 1'b1 || bus3.out !== 8'h00)
            $display("FAIL reset_small got=%b/%h exp=1/00",
                     bus3.in_ready, bus3.out);
        else passed++;
    endtask

    task automatic test_onehot_all();
        for (int s = 0; s < 32; s++) begin
            send(s, 0, 0);
            collect(100);
            total++;
            if (got_w.size() != 1 || got_w[0] !== ref_word(0, s))
                $display("FAIL onehot_sel%0d got=%h n=%0d exp=%h",
                         s, got_w.size() ? got_w[0] : 32'h0,
                         got_w.size(), ref_word(0, s));
            else passed++;
            total++;
            if (!got_done || done_out !== 32'h0 || done_vld !== 1'b0)
                $display("FAIL onehot_done%0d got=%0b/%h exp=1/0",
                         s, got_done, done_out);
            else passed++;
        end
    endtask

    task automatic test_therm_inv();
        send(5, 1, 0);
        collect(100);
        total++;
        if (got_w.size() != 1 || got_w[0] !== 32'h0000003F)
            $display("FAIL therm_sel5 got=%h exp=0000003f",
                     got_w.size() ? got_w[0] : 32'hx);
        else passed++;
        send(31, 3, 0);
        collect(100);
        total++;
        if (got_w.size() != 1 || got_w[0] !== 32'h7FFFFFFF)
            $display("FAIL inv_sel31 got=%h exp=7fffffff",
                     got_w.size() ? got_w[0] : 32'hx);
        else passed++;
    endtask

    task automatic test_hold_stall();
        int bad = 0;
        bus.out_ready = 1'b0;
        send(9, 0, 0);
        for (int c = 0; c < 10; c++) begin
            if (bus.out !== 32'h200 || bus.busy !== 1'b1 ||
                bus.out_valid !== 1'b1)
                bad++;
            @(negedge clk);
        end
        total++;
        if (bad != 0)
            $display("FAIL hold_stall got=%0d bad exp=0", bad);
        else passed++;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        total++;
        if (bus.done !== 1'b1 || bus.out !== 32'h0 ||
            bus.out_valid !== 1'b0)
            $display("FAIL hold_release got=%b/%h/%b exp=1/0/0",
                     bus.done, bus.out, bus.out_valid);
        else passed++;
        @(negedge clk);
        total++;
        if (bus.done !== 1'b0)
            $display("FAIL done_width got=%b exp=0", bus.done);
        else passed++;
    endtask

    task automatic test_scan_basic();
        int bad = 0;
        send(3, 2, 2);
        collect(100);
        total++;
        if (got_w.size() != 4)
            $display("FAIL scan_count got=%0d exp=4", got_w.size());
        else passed++;
        for (int i = 0; i < got_w.size() && i < 4; i++)
            if (got_w[i] !== ref_word(0, i) || got_gap[i] != 2) bad++;
        total++;
        if (bad != 0)
            $display("FAIL scan_words got=%0d bad exp=0", bad);
        else passed++;
        total++;
        if (!got_done || done_out !== 32'h0 || overlap != 0)
            $display("FAIL scan_done got=%0b/%h/%0d exp=1/0/0",
                     got_done, done_out, overlap);
        else passed++;
    endtask

    task automatic test_scan_full();
        int bad = 0;
        send(31, 2, 0);
        collect(100);
        total++;
        if (got_w.size() != 32)
            $display("FAIL full_count got=%0d exp=32", got_w.size());
        else passed++;
        for (int i = 0; i < got_w.size() && i < 32; i++)
            if (got_w[i] !== ref_word(0, i) || got_gap[i] != 0) bad++;
        total++;
        if (bad != 0)
            $display("FAIL full_words got=%0d bad exp=0", bad);
        else passed++;
        total++;
        if (!got_done || done_out !== 32'h0 ||
            (got_w.size() == 32 && got_w[31] !== 32'h80000000))
            $display("FAIL full_end got=%0b/%h exp=1/0",
                     got_done, done_out);
        else passed++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            int          m = int'($urandom_range(3));
            int          s = int'($urandom_range(31));
            int          d = int'($urandom_range(4));
            int          p = int'($urandom_range(100, 40));
            logic [31:0] exp_w[$];
            int          exp_g[$];
            int          bad = 0;
            if (m == 2) begin
                for (int i = 0; i <= s; i++) begin
                    exp_w.push_back(ref_word(0, i));
                    exp_g.push_back(d);
                end
            end else begin
                exp_w.push_back(ref_word(m, s));
                exp_g.push_back(0);
            end
            send(s, m, d);
            collect(p);
            if (got_w.size() != exp_w.size()) bad++;
            for (int i = 0; i < got_w.size() && i < exp_w.size(); i++)
                if (got_w[i] !== exp_w[i] || got_gap[i] != exp_g[i])
                    bad++;
            total++;
            if (bad != 0)
                $display("FAIL rand%0d m=%0d s=%0d d=%0d bad=%0d exp=0",
                         n, m, s, d, bad);
            else passed++;
            total++;
            if (!got_done || timed_out || stall_bad != 0 ||
                overlap != 0 || done_out !== 32'h0)
                $display("FAIL rand%0d_ctl got=%0b/%0d/%0d exp=1/0/0",
                         n, got_done, stall_bad, overlap);
            else passed++;
        end
    endtask

    task automatic test_reset_midscan();
        bit found = 0;
        int dones = 0;
        bus.out_ready = 1'b1;
        send(5, 2, 1);
        for (int c = 0; c < 50; c++) begin
            if (bus.out === 32'h4) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (!found)
            $display("FAIL midscan_reach got=0 exp=1");
        else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (bus.out !== 32'h0 || bus.out_valid !== 1'b0 ||
            bus.busy !== 1'b0 || bus.done !== 1'b0)
            $display("FAIL midscan_async got=%h/%b/%b exp=0/0/0",
                     bus.out, bus.out_valid, bus.busy);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (bus.done || bus.busy) dones++;
            @(negedge clk);
        end
        total++;
        if (dones != 0)
            $display("FAIL midscan_nodone got=%0d exp=0", dones);
        else passed++;
        send(1, 0, 0);
        collect(100);
        total++;
        if (got_w.size() != 1 || got_w[0] !== 32'h2 || !got_done)
            $display("FAIL midscan_next got=%0d/%0b exp=1/1",
                     got_w.size(), got_done);
        else passed++;
    endtask

    task automatic test_small_back_to_back();
        int bad = 0;
        bus3.out_ready = 1'b0;
        bus3.sel       = 3'd7;
        bus3.mode      = 2'b00;
        bus3.in_valid  = 1'b1;
        @(negedge clk);
        bus3.sel = 3'd2;
        total++;
        if (bus3.out !== 8'h80 || bus3.out_valid !== 1'b1)
            $display("FAIL small_sel7 got=%h exp=80", bus3.out);
        else passed++;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus3.in_ready !== 1'b0 || bus3.out !== 8'h80) bad++;
        end
        total++;
        if (bad != 0)
            $display("FAIL small_ignore got=%0d bad exp=0", bad);
        else passed++;
        bus3.out_ready = 1'b1;
        @(negedge clk);
        bus3.out_ready = 1'b0;
        total++;
        if (bus3.done !== 1'b1 || bus3.in_ready !== 1'b1 ||
            bus3.out !== 8'h00)
            $display("FAIL small_done got=%b/%b/%h exp=1/1/00",
                     bus3.done, bus3.in_ready, bus3.out);
        else passed++;
        @(negedge clk);
        bus3.in_valid = 1'b0;
        total++;
        if (bus3.out !== 8'h04 || bus3.out_valid !== 1'b1)
            $display("FAIL small_second got=%h exp=04", bus3.out);
        else passed++;
        bus3.out_ready = 1'b1;
        @(negedge clk);
        bus3.out_ready = 1'b0;
        total++;
        if (bus3.done !== 1'b1)
            $display("FAIL small_second_done got=%b exp=1", bus3.done);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_onehot_all();
        test_therm_inv();
        test_hold_stall();
        test_scan_basic();
        test_scan_full();
        test_random();
        test_reset_midscan();
        test_small_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/onehot_scan_decoder.md
ONEHOT_SCAN_DECODER -- requirements
Module: onehot_scan_decoder

Interface
REQ-001 SHALL have parameter SEL_W, default 5, select width (legal range 1..8).
REQ-002 SHALL have parameter DWELL_W, default 8, dwell counter width (legal range 1..16).
REQ-003 SHALL derive OUT_W = 2**SEL_W internally; it SHALL NOT be overridable.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port in_valid  input  1  command valid.
REQ-007 SHALL have port in_ready  output  1  command accepted when in_valid&&in_ready.
REQ-008 SHALL have port sel  input  SEL_W  decode index.
REQ-009 SHALL have port mode  input  2  00 one-hot, 01 thermometer, 10 scan, 11 active-low one-hot.
REQ-010 SHALL have port dwell  input  DWELL_W  idle cycles before each scan step.
REQ-011 SHALL have port out  output  OUT_W  registered decoded word.
REQ-012 SHALL have port out_valid  output  1  out qualified.
REQ-013 SHALL have port out_ready  input  1  consumer accepts out when out_valid&&out_ready.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse after final transfer of any command.

Function
REQ-016 SHALL implement states IDLE, HOLD, SCAN; in_ready = (state==IDLE); sel, mode, dwell captured only on acceptance.
REQ-017 Mode 00: SHALL go to HOLD next cycle with out bit sel set, all other bits 0 (latency 1 cycle).
REQ-018 Mode 01: SHALL go to HOLD with out bits 0..sel set, bits above sel clear.
REQ-019 Mode 11: SHALL go to HOLD with out = bitwise inverse of mode-00 result.
REQ-020 HOLD: out_valid=1; out SHALL remain stable until out_ready=1, then go to IDLE with done=1 for that next cycle.
REQ-021 Mode 10: SHALL go to SCAN with index idx=0, dwell counter cnt=captured dwell, out = one-hot(0).
REQ-022 SCAN: out = one-hot(idx) every cycle; cnt decrements by 1 per cycle while nonzero; out_valid = (cnt==0).
REQ-023 SCAN transfer with idx<sel: idx increments by 1, cnt reloads captured dwell, out updates next cycle.
REQ-024 SCAN transfer with idx==sel: SHALL go to IDLE, pulse done; idx compared before increment, never wraps (sel=OUT_W-1 legal).
REQ-025 out_ready low while out_valid high SHALL stall with out, idx, cnt unchanged.
REQ-026 dwell=0 SHALL give out_valid every cycle in SCAN (one step per accepted transfer).
REQ-027 On return to IDLE, out SHALL be cleared to 0 and out_valid=0.
REQ-028 in_valid in non-IDLE states SHALL be ignored; no command queued.
REQ-029 done and out_valid SHALL never be high in the same cycle.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, out=0, out_valid=0, busy=0, done=0, idx=0, cnt=0, regardless of operation in progress.
REQ-031 After rst_n deasserts, in_ready SHALL be 1 on the first clock edge.
REQ-032 Reset mid-SCAN SHALL discard the command; no done pulse produced.

Verification
REQ-033 Defaults, mode 00, sel=0..31 each, out_ready=1 -> out=1<<sel for one cycle, then done pulse, 32 commands.
REQ-034 Mode 01 sel=5 -> out=0x0000003F; mode 11 sel=31 -> out=0x7FFFFFFF; out_ready held low 10 cycles -> out stable, busy=1.
REQ-035 Mode 10 sel=3 dwell=2, out_ready=1 -> out 0x1,0x2,0x4,0x8 each valid after 2 gap cycles, 4 transfers, then done, out=0.
REQ-036 Mode 10 sel=31 dwell=0 -> 32 consecutive transfers ending 0x80000000, no wrap to 0x1, then IDLE.
REQ-037 rst_n pulsed low mid-scan at idx=2 -> out=0, out_valid=0 asynchronously, no done, next command accepted normally.
REQ-038 SEL_W=3 instance, mode 00 sel=7 -> out=8'h80; in_valid held during HOLD -> second command accepted only after done.
